// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default sample width, bit-counter sizing and the
// sample type used by both the transmit and receive blocks.
package i2s_pkg;

   localparam int I2S_BITS_DEFAULT = 24;

   // Counter must reach BITS_PRECISION itself (the saturated "frame done" value).
   function automatic int cnt_width(input int bits);
      return $clog2(bits + 1);
   endfunction

   localparam int I2S_CNT_W_DEFAULT = cnt_width(I2S_BITS_DEFAULT);

   typedef logic [I2S_BITS_DEFAULT-1:0] sample_t;

   // Transmit phase decoded from {enable, cnt}.
   typedef enum logic [1:0] {
      PH_IDLE,
      PH_SHIFT,
      PH_DONE
   } tx_phase_t;

endpackage

// File: rtl/i2s_tx_hold_buf.sv
// Single-entry valid/ready holding register in front of the I2S shifter.
// Ready depends only on registered state, so there is no combinational path
// from data_valid to data_ready.
module i2s_tx_hold_buf
   import i2s_pkg::*;
#(
   parameter int BITS_PRECISION = I2S_BITS_DEFAULT
)
(
   input  logic                      sck,
   input  logic                      rst_n,
   input  logic [BITS_PRECISION-1:0] data_in,
   input  logic                      data_valid,
   input  logic                      take,
   output logic [BITS_PRECISION-1:0] hold,
   output logic                      hold_full,
   output logic                      data_ready
);

   logic accept;

   assign data_ready = !hold_full;
   assign accept     = data_valid && !hold_full;

   // Occupancy flag: set on accept, cleared when the shifter takes the word.
   // take only happens while full and accept only while empty, so they never collide.
   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         hold_full <= 1'b0;
      end else if (accept) begin
         hold_full <= 1'b1;
      end else if (take) begin
         hold_full <= 1'b0;
      end
   end

   // Sample storage; qualified by hold_full, so it needs no reset.
   always_ff @(posedge sck) begin
      if (accept) begin
         hold <= data_in;
      end
   end

endmodule

// File: rtl/i2s_out_single_channel.sv
// Single-channel I2S transmitter. A sample is parked in the holding buffer,
// moved into the shift register on an idle (enable low) edge, and shifted out
// MSB-first during the channel's enabled bit slots. Frames with no loaded word
// send zeros and flag an underrun.
module i2s_out_single_channel
   import i2s_pkg::*;
#(
   parameter int BITS_PRECISION = I2S_BITS_DEFAULT
)
(
   input  logic                      sck,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic [BITS_PRECISION-1:0] data_out,
   input  logic                      data_valid,
   output logic                      data_ready,
   output logic                      sd,
   output logic                      word_done,
   output logic                      underrun
);

   localparam int              CNT_W    = cnt_width(BITS_PRECISION);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BITS_PRECISION);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS_PRECISION - 1);

   logic [BITS_PRECISION-1:0] hold;
   logic                      hold_full;
   logic                      take;

   logic [BITS_PRECISION-1:0] sreg, sreg_nxt;
   logic [CNT_W-1:0]          cnt, cnt_nxt;
   logic                      loaded, loaded_nxt, loaded_kept;
   logic                      word_done_nxt, underrun_nxt;
   tx_phase_t                 phase;

   i2s_tx_hold_buf #(
      .BITS_PRECISION (BITS_PRECISION)
   ) u_hold_buf (
      .sck        (sck),
      .rst_n      (rst_n),
      .data_in    (data_out),
      .data_valid (data_valid),
      .take       (take),
      .hold       (hold),
      .hold_full  (hold_full),
      .data_ready (data_ready)
   );

   // Phase decode and next-state for counter, shifter, load flag and pulses.
   always_comb begin
      phase         = PH_IDLE;
      cnt_nxt       = cnt;
      sreg_nxt      = sreg;
      loaded_nxt    = loaded;
      loaded_kept   = loaded;
      word_done_nxt = 1'b0;
      underrun_nxt  = 1'b0;
      take          = 1'b0;

      if (enable) begin
         phase = (cnt == CNT_FULL) ? PH_DONE : PH_SHIFT;
      end

      case (phase)
         PH_IDLE: begin
            cnt_nxt = '0;
            // A word that already started shifting is dropped; a word loaded
            // but not yet started (cnt==0) keeps waiting for its frame.
            loaded_kept = (cnt == '0) ? loaded : 1'b0;
            loaded_nxt  = loaded_kept;
            if (hold_full && !loaded_kept) begin
               sreg_nxt   = hold;
               loaded_nxt = 1'b1;
               take       = 1'b1;
            end
         end
         PH_SHIFT: begin
            sreg_nxt = sreg << 1;
            cnt_nxt  = cnt + CNT_W'(1);
            if ((cnt == '0) && !loaded) begin
               underrun_nxt = 1'b1;
            end
            if (cnt == CNT_LAST) begin
               loaded_nxt    = 1'b0;
               word_done_nxt = loaded;
            end
         end
         PH_DONE: begin
            // Enable held past the word length: hold everything, sd stays 0.
         end
         default: begin
            cnt_nxt = '0;
         end
      endcase
   end

   // Transmit state registers.
   always_ff @(posedge sck or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         sreg      <= '0;
         loaded    <= 1'b0;
         word_done <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         sreg      <= sreg_nxt;
         loaded    <= loaded_nxt;
         word_done <= word_done_nxt;
         underrun  <= underrun_nxt;
      end
   end

   // MSB is presented before the first enabled edge so the receiver sees it there.
   assign sd = (enable && loaded && (cnt < CNT_FULL)) ? sreg[BITS_PRECISION-1] : 1'b0;

endmodule

// File: tb/tb_i2s_out_single_channel.sv
// Directed bench for the single-channel I2S transmitter.
module tb_i2s_out_single_channel;
   import i2s_pkg::*;

   logic    sck;
   logic    rst_n;
   logic    enable;
   sample_t data_out;
   logic    data_valid;
   logic    data_ready;
   logic    sd;
   logic    word_done;
   logic    underrun;

   int n_cmp = 0;
   int n_err = 0;

   i2s_out_single_channel #(
      .BITS_PRECISION (24)
   ) dut (
      .sck        (sck),
      .rst_n      (rst_n),
      .enable     (enable),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .sd         (sd),
      .word_done  (word_done),
      .underrun   (underrun)
   );

   initial begin
      sck = 1'b0;
      forever #5 sck = ~sck;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge sck);
      #1;
   endtask

   // Drive n enabled cycles then one idle cycle; check sd, pulses and
   // optionally preload pw at cycle 3 and check ready stays low afterwards.
   task automatic run_frame(input string tag, input int n, input sample_t word,
                            input bit wd_exp, input bit ur_exp,
                            input bit pre, input sample_t pw);
      sample_t sh;
      sh = word;
      for (int i = 0; i <= n; i++) begin
         enable = (i < n);
         if (pre && i == 3) begin
            data_out   = pw;
            data_valid = 1'b1;
         end else begin
            data_valid = 1'b0;
         end
         #1;
         check({tag, "_sd"}, 32'(sd), 32'(((i < n) && (i < 24)) ? sh[23] : 1'b0));
         check({tag, "_word_done"}, 32'(word_done), 32'(wd_exp && (i == 24)));
         check({tag, "_underrun"}, 32'(underrun), 32'(ur_exp && (i == 1)));
         if (pre && i >= 4) begin
            check({tag, "_ready_low"}, 32'(data_ready), 32'd0);
         end
         sh = sh << 1;
         step();
      end
   endtask

   // Offer one word on an idle edge, then one more idle edge to load it.
   task automatic load_word(input string tag, input sample_t w);
      enable     = 1'b0;
      data_out   = w;
      data_valid = 1'b1;
      #1;
      check({tag, "_ready_pre"}, 32'(data_ready), 32'd1);
      step();
      data_valid = 1'b0;
      #1;
      check({tag, "_ready_held"}, 32'(data_ready), 32'd0);
      step();
      #1;
      check({tag, "_ready_loaded"}, 32'(data_ready), 32'd1);
   endtask

   initial begin
      sample_t sh;
      rst_n      = 1'b1;
      enable     = 1'b0;
      data_out   = '0;
      data_valid = 1'b0;

      // Reset with enable high so sd=0 really comes from the cleared state.
      #2;
      rst_n  = 1'b0;
      enable = 1'b1;
      #1;
      check("rst_ready", 32'(data_ready), 32'd1);
      check("rst_sd", 32'(sd), 32'd0);
      step();
      step();
      check("rst_word_done", 32'(word_done), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
      check("rst_sd_hold", 32'(sd), 32'd0);
      enable = 1'b0;
      rst_n  = 1'b1;

      // Test 1 + 2: A5C3F0 with 800001 preloaded during the shift.
      load_word("t1", 24'hA5C3F0);
      run_frame("t1", 24, 24'hA5C3F0, 1'b1, 1'b0, 1'b1, 24'h800001);
      enable = 1'b0;
      #1;
      check("t2_ready_after_load", 32'(data_ready), 32'd1);
      step();
      run_frame("t2", 24, 24'h800001, 1'b1, 1'b0, 1'b0, 24'h0);

      // Test 3: nothing offered.
      step();
      run_frame("t3", 24, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h0);

      // Test 4: all ones, enable dropped after 10 bits, next frame underruns.
      load_word("t4", 24'hFFFFFF);
      run_frame("t4", 10, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 24'h0);
      step();
      run_frame("t4_next", 24, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h0);

      // Test 5: enable held 30 cycles.
      load_word("t5", 24'h000001);
      run_frame("t5", 30, 24'h000001, 1'b1, 1'b0, 1'b0, 24'h0);

      // Test 6: reset at bit 12 with a second word held.
      load_word("t6", 24'hC0FFEE);
      sh = 24'hC0FFEE;
      for (int i = 0; i < 12; i++) begin
         enable = 1'b1;
         if (i == 3) begin
            data_out   = 24'h123456;
            data_valid = 1'b1;
         end else begin
            data_valid = 1'b0;
         end
         #1;
         check("t6_sd", 32'(sd), 32'(sh[23]));
         sh = sh << 1;
         step();
      end
      #1;
      check("t6_ready_busy", 32'(data_ready), 32'd0);
      check("t6_sd_bit12", 32'(sd), 32'(sh[23]));
      rst_n = 1'b0;
      #1;
      check("t6_sd_async", 32'(sd), 32'd0);
      check("t6_ready_rst", 32'(data_ready), 32'd1);
      step();
      rst_n  = 1'b1;
      enable = 1'b0;
      #1;
      check("t6_ready_after", 32'(data_ready), 32'd1);
      step();
      run_frame("t6_next", 24, 24'h000000, 1'b0, 1'b1, 1'b0, 24'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
